// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler sharing one echo-timing engine across several HC-SR04-style sensors.
// Each shot: trigger pulse, echo capture with timeout, cm conversion by counting, then a fixed-period gap.
module ultrasonic_scan_scheduler #(
  parameter int unsigned N_SENSORS      = 4,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CYCLES_PER_CM  = 2915,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned PERIOD_CYCLES  = 3000000,
  localparam int unsigned ID_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trigger,
  output logic                 meas_valid,
  output logic [ID_W-1:0]      meas_id,
  output logic [15:0]          meas_cm,
  output logic                 meas_timeout,
  output logic                 busy
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CM_LAST   = CNT_W'(CYCLES_PER_CM - 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  // GAP leaves one cycle for SELECT so trigger rises land exactly PERIOD_CYCLES apart
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(PERIOD_CYCLES - 2);
  localparam logic [ID_W-1:0]  ID_INIT   = ID_W'(N_SENSORS - 1);
  localparam logic [N_SENSORS-1:0] ONE_HOT0 = N_SENSORS'(1);
  localparam logic [15:0] CM_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE, SELECT, TRIG, WAIT_HIGH, MEASURE, REPORT, GAP
  } state_t;

  state_t               state;
  logic [ID_W-1:0]      cur;
  logic [ID_W-1:0]      last_id;
  logic [CNT_W-1:0]     trig_cnt;
  logic [CNT_W-1:0]     period_cnt;
  logic [CNT_W-1:0]     tmo_cnt;
  logic [CNT_W-1:0]     sub_cnt;
  logic [15:0]          cm;
  logic [N_SENSORS-1:0] echo_s1;
  logic [N_SENSORS-1:0] echo_s2;
  logic                 sel_echo;
  logic [ID_W-1:0]      pick;
  logic [ID_W-1:0]      pick_hi;
  logic [ID_W-1:0]      pick_lo;
  logic                 hi_found;

  // Two-flop synchronizer on every raw echo pin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
    end
  end

  assign sel_echo = echo_s2[cur];

  // Next sensor: lowest set mask bit above last_id, else lowest set bit overall
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    hi_found = 1'b0;
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (sensor_mask[ID_W'(i)]) begin
        pick_lo = ID_W'(i);
        if (ID_W'(i) > last_id) begin
          pick_hi  = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    pick = hi_found ? pick_hi : pick_lo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cur          <= '0;
      last_id      <= ID_INIT;
      trigger      <= '0;
      trig_cnt     <= '0;
      period_cnt   <= '0;
      tmo_cnt      <= '0;
      sub_cnt      <= '0;
      cm           <= '0;
      meas_valid   <= 1'b0;
      meas_id      <= '0;
      meas_cm      <= '0;
      meas_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      // Free-running since the last trigger rise; saturates instead of wrapping
      if (period_cnt != '1) period_cnt <= period_cnt + CNT_W'(1);

      unique case (state)
        IDLE: begin
          if (enable && (|sensor_mask)) begin
            state <= SELECT;
            busy  <= 1'b1;
          end
        end

        SELECT: begin
          if (!(|sensor_mask)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cur        <= pick;
            last_id    <= pick;
            trigger    <= ONE_HOT0 << pick;
            trig_cnt   <= '0;
            period_cnt <= '0;
            state      <= TRIG;
          end
        end

        TRIG: begin
          if (trig_cnt == TRIG_LAST) begin
            trigger <= '0;
            tmo_cnt <= CNT_W'(1);
            state   <= WAIT_HIGH;
          end else begin
            trig_cnt <= trig_cnt + CNT_W'(1);
          end
        end

        WAIT_HIGH, MEASURE: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (tmo_cnt >= TMO_LIMIT) begin
            state        <= REPORT;
            meas_valid   <= 1'b1;
            meas_id      <= cur;
            meas_cm      <= CM_SAT;
            meas_timeout <= 1'b1;
          end else if (state == WAIT_HIGH) begin
            // The first high cycle already counts toward the distance
            if (sel_echo) begin
              state   <= MEASURE;
              sub_cnt <= (CM_LAST == '0) ? '0 : CNT_W'(1);
              cm      <= (CM_LAST == '0) ? 16'd1 : 16'd0;
            end
          end else if (!sel_echo) begin
            state        <= REPORT;
            meas_valid   <= 1'b1;
            meas_id      <= cur;
            meas_cm      <= cm;
            meas_timeout <= 1'b0;
          end else if (sub_cnt == CM_LAST) begin
            sub_cnt <= '0;
            if (cm != CM_SAT) cm <= cm + 16'd1;
          end else begin
            sub_cnt <= sub_cnt + CNT_W'(1);
          end
        end

        REPORT: begin
          state <= GAP;
        end

        GAP: begin
          if (period_cnt >= GAP_LAST) begin
            if (enable) begin
              state <= SELECT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
